// File: rtl/calc_op_scheduler.sv
// Purpose: sequences one arithmetic command at a time: start pulse, wait for done (with timeout), range-check, latch display result.
// Latency: accept at E0 -> start in E0..E1; done sampled at Ed -> result_valid in Ed+1..Ed+2 (op>=4: result two cycles after accept).
// Backpressure: cmd_ready only in IDLE and never while clear is high; a single command is in flight at any time.
//
// Ports:
//   clk_fpga_100mhz, reset (async, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_operand  command handshake from the interpreter
//   clear                                   synchronous abort; wins over a simultaneous command
//   unit_start/unit_operand/unit_done       one-hot start, held operand, per-unit done
//   res_sign/res_whole/res_frac             selected unit's result, valid with its done
//   output_number/output_sign/data_state    held display result (data_state: 0 input, 1 output, 2 error)
//   result_valid                            one-cycle pulse when the display result updates
//   busy                                    high in ISSUE, WAIT, CAPTURE
module calc_op_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMER_W        = 10
) (
    input  logic        clk_fpga_100mhz,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [9:0]  cmd_operand,
    input  logic        clear,
    output logic [3:0]  unit_start,
    output logic [9:0]  unit_operand,
    input  logic [3:0]  unit_done,
    input  logic        res_sign,
    input  logic [6:0]  res_whole,
    input  logic [6:0]  res_frac,
    output logic [13:0] output_number,
    output logic        output_sign,
    output logic [1:0]  data_state,
    output logic        result_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         op_q;        // only legal ops reach ISSUE/WAIT, so two bits suffice
    logic [9:0]         operand_q;
    logic               err_q;
    logic               sign_q;
    logic [6:0]         whole_q;
    logic [6:0]         frac_q;
    logic [TIMER_W-1:0] timer_q;

    logic               accept;
    logic               done_hit;
    logic               timeout_hit;
    logic               range_bad;
    logic [13:0]        number_calc;

    assign unit_operand = operand_q;
    assign busy         = (state_q != S_IDLE);
    assign range_bad    = err_q || (whole_q > 7'd99) || (frac_q > 7'd99);
    assign number_calc  = 14'(whole_q) * 14'd100 + 14'(frac_q);

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        unit_start  = 4'b0000;
        accept      = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = !clear;
                if (cmd_valid && !clear) begin
                    accept  = 1'b1;
                    // illegal / no-op codes skip the units and report an error
                    state_d = (cmd_op <= 3'd3) ? S_ISSUE : S_CAPTURE;
                end
            end
            S_ISSUE: begin
                unit_start = 4'b0001 << op_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                done_hit    = unit_done[op_q];
                // a done arriving on the last timer cycle still counts as success
                timeout_hit = !done_hit && (timer_q == TIMER_LAST);
                if (done_hit || timeout_hit) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clear) begin
            state_d    = S_IDLE;
            unit_start = 4'b0000;
        end
    end

    always_ff @(posedge clk_fpga_100mhz or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            op_q          <= 2'd0;
            operand_q     <= 10'd0;
            err_q         <= 1'b0;
            sign_q        <= 1'b0;
            whole_q       <= 7'd0;
            frac_q        <= 7'd0;
            timer_q       <= '0;
            output_number <= 14'd0;
            output_sign   <= 1'b0;
            data_state    <= 2'd0;
            result_valid  <= 1'b0;
        end else begin
            state_q      <= state_d;
            result_valid <= 1'b0;
            if (clear) begin
                err_q         <= 1'b0;
                output_number <= 14'd0;
                output_sign   <= 1'b0;
                data_state    <= 2'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            op_q       <= cmd_op[1:0];
                            operand_q  <= cmd_operand;
                            err_q      <= (cmd_op > 3'd3);
                            data_state <= 2'd0;
                        end
                    end
                    S_ISSUE: begin
                        timer_q <= '0;
                    end
                    S_WAIT: begin
                        timer_q <= timer_q + TIMER_W'(1);
                        if (done_hit) begin
                            sign_q  <= res_sign;
                            whole_q <= res_whole;
                            frac_q  <= res_frac;
                        end
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        result_valid <= 1'b1;
                        if (range_bad) begin
                            data_state    <= 2'd2;
                            output_number <= 14'd0;
                            output_sign   <= 1'b0;
                        end else begin
                            data_state    <= 2'd1;
                            output_number <= number_calc;
                            output_sign   <= sign_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Scoreboard bench for calc_op_scheduler: expected results are queued at command
// issue and popped by a monitor on every result_valid pulse.
module tb_calc_op_scheduler;

    logic        clk_fpga_100mhz = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [9:0]  cmd_operand;
    logic        clear;
    logic [3:0]  unit_start;
    logic [9:0]  unit_operand;
    logic [3:0]  unit_done;
    logic        res_sign;
    logic [6:0]  res_whole;
    logic [6:0]  res_frac;
    logic [13:0] output_number;
    logic        output_sign;
    logic [1:0]  data_state;
    logic        result_valid;
    logic        busy;

    calc_op_scheduler dut (
        .clk_fpga_100mhz (clk_fpga_100mhz),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_operand     (cmd_operand),
        .clear           (clear),
        .unit_start      (unit_start),
        .unit_operand    (unit_operand),
        .unit_done       (unit_done),
        .res_sign        (res_sign),
        .res_whole       (res_whole),
        .res_frac        (res_frac),
        .output_number   (output_number),
        .output_sign     (output_sign),
        .data_state      (data_state),
        .result_valid    (result_valid),
        .busy            (busy)
    );

    always #5 clk_fpga_100mhz = ~clk_fpga_100mhz;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  ds;
        logic [13:0] num;
        logic        sign;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] ds, input logic [13:0] num, input logic sign);
        exp_t e;
        e.ds   = ds;
        e.num  = num;
        e.sign = sign;
        return e;
    endfunction

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk_fpga_100mhz) begin
        if (reset && result_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_state", data_state, e.ds);
                chk("output_number", output_number, e.num);
                chk("output_sign", output_sign, e.sign);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_fpga_100mhz);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge two cycles after acceptance.
    task automatic send(input logic [2:0] op, input logic [9:0] opd);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opd;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk_fpga_100mhz);
        cmd_valid = 1'b0;
        chk("start_issue", unit_start, (op <= 3) ? (1 << op) : 0);
        chk("data_state_on_accept", data_state, 0);
        chk("busy_after_accept", busy, 1);
        @(negedge clk_fpga_100mhz);
        chk("start_one_cycle", unit_start, 0);
        if (op <= 3) chk("unit_operand", unit_operand, opd);
    endtask

    // Drives a done pulse that the DUT should accept, then checks capture latency.
    task automatic done_pulse(input logic [3:0] mask, input logic s, input logic [6:0] w, input logic [6:0] f);
        unit_done = mask;
        res_sign  = s;
        res_whole = w;
        res_frac  = f;
        @(negedge clk_fpga_100mhz);
        unit_done = 4'b0;
        res_sign  = 1'b0;
        res_whole = 7'd0;
        res_frac  = 7'd0;
        chk("capture_busy", busy, 1);
        chk("no_early_result", result_valid, 0);
        @(negedge clk_fpga_100mhz);
        chk("result_valid_latency", result_valid, 1);
        chk("busy_dropped", busy, 0);
        chk("cmd_ready_after", cmd_ready, 1);
    endtask

    initial begin
        reset       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_operand = 10'd0;
        clear       = 1'b0;
        unit_done   = 4'b0;
        res_sign    = 1'b0;
        res_whole   = 7'd0;
        res_frac    = 7'd0;

        idle(2);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_unit_start", unit_start, 0);
        chk("rst_data_state", data_state, 0);
        chk("rst_output_number", output_number, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_unit_operand", unit_operand, 0);
        reset = 1'b1;
        idle(1);

        // SQUARE 12: done 5 cycles after start, 1.44 -> 144
        exp_q.push_back(mk(2'd1, 14'd144, 1'b0));
        send(3'd3, 10'd12);
        idle(4);
        done_pulse(4'b1000, 1'b0, 7'd1, 7'd44);

        // SIN: a stray COS done is ignored, then -0.50
        exp_q.push_back(mk(2'd1, 14'd50, 1'b1));
        send(3'd0, 10'd7);
        idle(2);
        unit_done = 4'b0010;
        res_sign  = 1'b1;
        res_whole = 7'd99;
        res_frac  = 7'd99;
        @(negedge clk_fpga_100mhz);
        unit_done = 4'b0;
        idle(1);
        chk("other_done_ignored", busy, 1);
        done_pulse(4'b0001, 1'b1, 7'd0, 7'd50);

        // NO_OPERATION and an illegal code both report an error without a start
        exp_q.push_back(mk(2'd2, 14'd0, 1'b0));
        send(3'd4, 10'd0);
        exp_q.push_back(mk(2'd2, 14'd0, 1'b0));
        send(3'd7, 10'd5);

        // Largest in-range value
        exp_q.push_back(mk(2'd1, 14'd9999, 1'b0));
        send(3'd3, 10'd99);
        done_pulse(4'b1000, 1'b0, 7'd99, 7'd99);

        // COS timeout: WAIT lasts exactly TIMEOUT_CYCLES cycles
        exp_q.push_back(mk(2'd2, 14'd0, 1'b0));
        send(3'd1, 10'd3);
        idle(1023);
        chk("timeout_still_waiting", busy, 1);
        chk("timeout_no_early_result", result_valid, 0);
        idle(1);
        chk("timeout_capture_busy", busy, 1);
        idle(1);
        chk("timeout_busy_dropped", busy, 0);
        chk("timeout_cmd_ready", cmd_ready, 1);

        // Done on the timeout cycle wins
        exp_q.push_back(mk(2'd1, 14'd123, 1'b0));
        send(3'd1, 10'd4);
        idle(1023);
        done_pulse(4'b0010, 1'b0, 7'd1, 7'd23);

        // Range errors on whole and on frac
        exp_q.push_back(mk(2'd2, 14'd0, 1'b0));
        send(3'd3, 10'd100);
        idle(1);
        done_pulse(4'b1000, 1'b0, 7'd100, 7'd0);
        exp_q.push_back(mk(2'd2, 14'd0, 1'b0));
        send(3'd2, 10'd9);
        done_pulse(4'b0100, 1'b0, 7'd5, 7'd100);

        // Clear during WAIT beats a simultaneous command
        exp_q.push_back(mk(2'd1, 14'd777, 1'b1));
        send(3'd3, 10'd20);
        done_pulse(4'b1000, 1'b1, 7'd7, 7'd77);
        send(3'd1, 10'd1);
        idle(2);
        clear       = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = 3'd3;
        cmd_operand = 10'd5;
        chk("clear_cmd_ready", cmd_ready, 0);
        @(negedge clk_fpga_100mhz);
        clear     = 1'b0;
        cmd_valid = 1'b0;
        chk("clear_busy", busy, 0);
        chk("clear_output_number", output_number, 0);
        chk("clear_output_sign", output_sign, 0);
        chk("clear_data_state", data_state, 0);
        chk("clear_unit_start", unit_start, 0);
        unit_done = 4'b0010;
        res_whole = 7'd3;
        @(negedge clk_fpga_100mhz);
        unit_done = 4'b0;
        res_whole = 7'd0;
        idle(2);
        chk("clear_late_done_ignored", busy, 0);

        // Async reset during WAIT
        exp_q.push_back(mk(2'd1, 14'd777, 1'b1));
        send(3'd3, 10'd20);
        done_pulse(4'b1000, 1'b1, 7'd7, 7'd77);
        send(3'd3, 10'd21);
        idle(3);
        reset = 1'b0;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_cmd_ready", cmd_ready, 1);
        chk("areset_output_number", output_number, 0);
        chk("areset_output_sign", output_sign, 0);
        chk("areset_unit_operand", unit_operand, 0);
        @(negedge clk_fpga_100mhz);
        reset = 1'b1;
        idle(1);
        unit_done = 4'b1000;
        res_whole = 7'd2;
        @(negedge clk_fpga_100mhz);
        unit_done = 4'b0;
        res_whole = 7'd0;
        idle(2);
        chk("areset_late_done_busy", busy, 0);
        chk("areset_late_done_number", output_number, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
